// File: rtl/uart_rx_341457971277988435.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
// Optional "Hello World!\n" message checker enabled by defining HELLO_CHECK_EN.
module uart_rx_341457971277988435 #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       msg_ok
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(CLKS_PER_BIT - 1);
    localparam logic [3:0] CNT_MID  = 4'(CLKS_PER_BIT / 2);

    logic       r_sync1;
    logic       r_sync2;
    logic       w_rxs;
    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [2:0] r_bit_idx;
    logic [2:0] w_bit_idx_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic       w_load;
    logic       w_ferr;

    assign w_rxs = r_sync2;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_load        = 1'b0;
        w_ferr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt     = 4'd0;
                w_bit_idx_nxt = 3'd0;
                if (!w_rxs) begin
                    // With one clock per bit the detection cycle is already the start-bit sample.
                    if (CLKS_PER_BIT == 1) begin
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_START;
                        w_cnt_nxt   = 4'd1;
                    end
                end
            end
            S_START: begin
                if (r_cnt == CNT_MID) begin
                    w_cnt_nxt     = 4'd0;
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = w_rxs ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt              = 4'd0;
                    w_shift_nxt[r_bit_idx] = w_rxs;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = 4'd0;
                    if (w_rxs) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_WAIT_IDLE: begin
                w_cnt_nxt = 4'd0;
                if (w_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_sync1   <= uart_rx;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            rx_valid  <= w_load;
            frame_err <= w_ferr;
            if (w_load) begin
                rx_data <= r_shift;
            end
        end
    end

`ifdef HELLO_CHECK_EN
    logic [3:0] r_msg_idx;
    logic [7:0] w_exp_byte;

    function automatic logic [7:0] hello_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    hello_byte = 8'h48;
            4'd1:    hello_byte = 8'h65;
            4'd2:    hello_byte = 8'h6C;
            4'd3:    hello_byte = 8'h6C;
            4'd4:    hello_byte = 8'h6F;
            4'd5:    hello_byte = 8'h20;
            4'd6:    hello_byte = 8'h57;
            4'd7:    hello_byte = 8'h6F;
            4'd8:    hello_byte = 8'h72;
            4'd9:    hello_byte = 8'h6C;
            4'd10:   hello_byte = 8'h64;
            4'd11:   hello_byte = 8'h21;
            4'd12:   hello_byte = 8'h0A;
            default: hello_byte = 8'h00;
        endcase
    endfunction

    assign w_exp_byte = hello_byte(r_msg_idx);

    // Evaluated on the load cycle so msg_ok lines up with the rx_valid it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_msg_idx <= 4'd0;
            msg_ok    <= 1'b0;
        end else begin
            msg_ok <= 1'b0;
            if (w_ferr) begin
                r_msg_idx <= 4'd0;
            end else if (w_load) begin
                if (r_shift == w_exp_byte) begin
                    if (r_msg_idx == 4'd12) begin
                        r_msg_idx <= 4'd0;
                        msg_ok    <= 1'b1;
                    end else begin
                        r_msg_idx <= r_msg_idx + 4'd1;
                    end
                end else begin
                    r_msg_idx <= (r_shift == 8'h48) ? 4'd1 : 4'd0;
                end
            end
        end
    end
`else
    assign msg_ok = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_341457971277988435.sv
// Bench for uart_rx_341457971277988435: two instances (1 and 4 clocks per bit) checked
// every cycle against a frame-level timing model; honours HELLO_CHECK_EN for msg_ok.
module tb_uart_rx_341457971277988435;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       line_a = 1'b1;
    logic       line_b = 1'b1;
    logic [7:0] rxd_a, rxd_b;
    logic       rv_a, rv_b, fe_a, fe_b, mo_a, mo_b;

    uart_rx_341457971277988435 #(.CLKS_PER_BIT(1)) u_dut_a (
        .clk(clk), .reset(reset), .uart_rx(line_a),
        .rx_data(rxd_a), .rx_valid(rv_a), .frame_err(fe_a), .msg_ok(mo_a)
    );

    uart_rx_341457971277988435 #(.CLKS_PER_BIT(4)) u_dut_b (
        .clk(clk), .reset(reset), .uart_rx(line_b),
        .rx_data(rxd_b), .rx_valid(rv_b), .frame_err(fe_b), .msg_ok(mo_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected events keyed by (edge index * 2 + instance).
    bit         exp_v[int];
    bit         exp_e[int];
    logic [7:0] exp_d[int];
    bit         exp_m[int];
    logic [7:0] md[2];
    int         mi[2];
    int         nv[2], ne[2], nm[2], lv_edge[2], sched_v[2];
    bit         run_cmp = 1'b0;

    logic [7:0] hello[13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                              8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int cpb(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    task automatic set_line(input int u, input logic v);
        if (u == 0) line_a = v;
        else        line_b = v;
    endtask

    task automatic idle(input int u, input int n);
        set_line(u, 1'b1);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 10-bit frame starting at a negedge; schedules the outcome in the model.
    // Start sample lands CLKS_PER_BIT/2 edges after detection (2 sync edges), stop sample 9 bits later.
    task automatic send_frame(input int u, input logic [7:0] d, input logic stop, output int p0);
        int  key;
        bit  m;
        p0  = cyc + 1;
        key = (p0 + 2 + cpb(u) / 2 + 9 * cpb(u)) * 2 + u;
        m   = 1'b0;
        if (stop) begin
            exp_v[key] = 1'b1;
            exp_d[key] = d;
            sched_v[u]++;
            if (d == hello[mi[u]]) begin
                if (mi[u] == 12) begin
                    m     = 1'b1;
                    mi[u] = 0;
                end else begin
                    mi[u]++;
                end
            end else begin
                mi[u] = (d == 8'h48) ? 1 : 0;
            end
`ifdef HELLO_CHECK_EN
            if (m) exp_m[key] = 1'b1;
`endif
        end else begin
            exp_e[key] = 1'b1;
            mi[u]      = 0;
        end
        set_line(u, 1'b0);
        repeat (cpb(u)) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(u, d[i]);
            repeat (cpb(u)) @(negedge clk);
        end
        set_line(u, stop);
        repeat (cpb(u)) @(negedge clk);
    endtask

    task automatic clear_model();
        exp_v.delete();
        exp_e.delete();
        exp_d.delete();
        exp_m.delete();
        for (int u = 0; u < 2; u++) begin
            md[u] = 8'h00;
            mi[u] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp && reset) begin
            for (int u = 0; u < 2; u++) begin
                int         key;
                logic [7:0] ad;
                logic       av, ae, am;
                key = cyc * 2 + u;
                ad  = (u == 0) ? rxd_a : rxd_b;
                av  = (u == 0) ? rv_a  : rv_b;
                ae  = (u == 0) ? fe_a  : fe_b;
                am  = (u == 0) ? mo_a  : mo_b;
                if (exp_v.exists(key)) md[u] = exp_d[key];
                if (av) begin
                    nv[u]++;
                    lv_edge[u] = cyc;
                end
                if (ae) ne[u]++;
                if (am) nm[u]++;
                check($sformatf("rx_valid[%0d]", u), av, exp_v.exists(key));
                check($sformatf("frame_err[%0d]", u), ae, exp_e.exists(key));
                check($sformatf("msg_ok[%0d]", u), am, exp_m.exists(key));
                check($sformatf("rx_data[%0d]", u), ad, md[u]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int v0, e0, m0;
        logic [7:0] d;
        logic       s;

        clear_model();
        for (int u = 0; u < 2; u++) begin
            nv[u] = 0; ne[u] = 0; nm[u] = 0; lv_edge[u] = 0; sched_v[u] = 0;
        end

        #1;
        check("reset_outs_a", {rxd_a, rv_a, fe_a, mo_a}, 32'h0);
        check("reset_outs_b", {rxd_b, rv_b, fe_b, mo_b}, 32'h0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        run_cmp = 1'b1;

        // Single 0x48 frame at one clock per bit: pulse 11 edges after line first goes low.
        idle(0, 4);
        send_frame(0, 8'h48, 1'b1, p);
        idle(0, 6);
        check("lit_0x48_data", rxd_a, 8'h48);
        check("lit_0x48_edge", lv_edge[0], p + 11);
        check("lit_0x48_nvalid", nv[0], 1);
        check("lit_0x48_nerr", ne[0], 0);

        // Back-to-back message, then 11 idle cycles.
        v0 = nv[0];
        m0 = nm[0];
        for (int i = 0; i < 13; i++) send_frame(0, hello[i], 1'b1, p);
        idle(0, 11);
        idle(0, 4);
        check("hello_nvalid", nv[0] - v0, 13);
        check("hello_last_byte", rxd_a, 8'h0A);
`ifdef HELLO_CHECK_EN
        check("hello_nmsg", nm[0] - m0, 1);
`else
        check("hello_nmsg", nm[0] - m0, 0);
`endif

        // Restart mid-message: "He" then the full message.
        m0 = nm[0];
        send_frame(0, 8'h48, 1'b1, p);
        send_frame(0, 8'h65, 1'b1, p);
        for (int i = 0; i < 13; i++) send_frame(0, hello[i], 1'b1, p);
        idle(0, 12);
`ifdef HELLO_CHECK_EN
        check("hehello_nmsg", nm[0] - m0, 1);
`else
        check("hehello_nmsg", nm[0] - m0, 0);
`endif

        // Bad stop bit, line held low 5 more cycles, then recovery.
        v0 = nv[0];
        e0 = ne[0];
        send_frame(0, 8'h55, 1'b0, p);
        repeat (5) @(negedge clk);
        idle(0, 6);
        check("ferr_nerr", ne[0] - e0, 1);
        check("ferr_nvalid", nv[0] - v0, 0);
        check("ferr_data_held", rxd_a, 8'h0A);
        send_frame(0, 8'h3C, 1'b1, p);
        idle(0, 6);
        check("after_ferr_data", rxd_a, 8'h3C);

        // Reset pulsed while data bit 4 is on the line.
        d = 8'h96;
        set_line(0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            set_line(0, d[i]);
            @(negedge clk);
        end
        set_line(0, d[4]);
        #2 reset = 1'b0;
        #1;
        check("midreset_outs_a", {rxd_a, rv_a, fe_a, mo_a}, 32'h0);
        check("midreset_outs_b", {rxd_b, rv_b, fe_b, mo_b}, 32'h0);
        clear_model();
        set_line(0, 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        v0 = nv[0];
        @(negedge clk);
        idle(0, 4);
        send_frame(0, 8'h21, 1'b1, p);
        idle(0, 6);
        check("postreset_data", rxd_a, 8'h21);
        check("postreset_nvalid", nv[0] - v0, 1);

        // Four clocks per bit: one-cycle glitch is rejected, next frame is received.
        v0 = nv[1];
        e0 = ne[1];
        idle(1, 4);
        set_line(1, 1'b0);
        @(negedge clk);
        idle(1, 10);
        check("glitch_nvalid", nv[1] - v0, 0);
        check("glitch_nerr", ne[1] - e0, 0);
        send_frame(1, 8'hA5, 1'b1, p);
        idle(1, 14);
        check("lit_0xa5_data", rxd_b, 8'hA5);
        check("lit_0xa5_edge", lv_edge[1], p + 40);

        // Random traffic on both instances, occasional bad stop bits.
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 30; n++) begin
                d = 8'($urandom);
                s = ($urandom_range(0, 7) != 0);
                send_frame(u, d, s, p);
                if (!s) idle(u, 2 * cpb(u) + 4 + $urandom_range(0, 3));
                else    idle(u, $urandom_range(0, 3));
            end
            idle(u, 20);
            check($sformatf("random_nvalid[%0d]", u), nv[u], sched_v[u]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
